// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial sequential ALU.
// Optional multiplier is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SHL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    localparam flags_t     FLAGS_CLR   = 4'b0000;
    localparam int         BUSY_B      = 2;
    localparam int         VALID_B     = 3;
    localparam int         Z_B         = 4;
    localparam int         N_B         = 5;
    localparam int         C_B         = 6;
    localparam int         V_B         = 7;
    localparam logic [7:0] UIO_OE_MASK = 8'hFC;

    function automatic logic [7:0] pack_status(input flags_t f, input logic valid, input logic busy);
        logic [7:0] s;
        s          = 8'h00;
        s[BUSY_B]  = busy;
        s[VALID_B] = valid;
        s[Z_B]     = f.z;
        s[N_B]     = f.n;
        s[C_B]     = f.c;
        s[V_B]     = f.v;
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational datapath: single-cycle ops 0-6 and pass-through of A for opcode 7.
// The sequential multiplier (ALU_SEQ_MUL_EN) lives in the top level, not here.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             z_o,
    output logic             n_o,
    output logic             c_o,
    output logic             v_o
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_s = {1'b0, a_i} - {1'b0, b_i};

    // Operation select and flag derivation; C on SUB means "no borrow".
    always_comb begin
        result_o = a_i;
        c_o      = 1'b0;
        v_o      = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum_s[WIDTH-1:0];
                c_o      = sum_s[WIDTH];
                v_o      = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o = diff_s[WIDTH-1:0];
                c_o      = ~diff_s[WIDTH];
                v_o      = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SHL:  result_o = a_i << b_i[SW-1:0];
            default: result_o = a_i;
        endcase
        z_o = (result_o == {WIDTH{1'b0}});
        n_o = result_o[WIDTH-1];
    end

endmodule

// File: rtl/tt_um_alu_seq.sv
// Tiny Tapeout top: strobe-driven byte-serial operand load, execute, byte readout.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle shift-add multiplier for opcode 7.
module tt_um_alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic             stb_q, stb_d;
    logic [7:0]       uo_out_q, uo_out_d;
    logic [7:0]       uio_out_q, uio_out_d;

    logic             ev_s;
    logic             abort_s;
    logic             last_byte_s;
    logic [WIDTH-1:0] core_result_s;
    logic             core_z_s, core_n_s, core_c_s, core_v_s;
    flags_t           core_flags_s;
    logic             unused_ok_s;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mul_sum_s;
    flags_t             mul_flags_s;

    // One partial product per EXEC cycle: add A shifted by the current bit position of B.
    assign mul_sum_s   = prod_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : {(2*WIDTH){1'b0}});
    assign mul_flags_s = {1'b0, |mul_sum_s[2*WIDTH-1:WIDTH], mul_sum_s[WIDTH-1],
                          (mul_sum_s[WIDTH-1:0] == {WIDTH{1'b0}})};
`endif

    assign ev_s         = ena & uio_in[0] & ~stb_q;
    assign abort_s      = ena & uio_in[1];
    assign last_byte_s  = (idx_q == IW'(NB - 1));
    assign core_flags_s = {core_v_s, core_c_s, core_n_s, core_z_s};
    assign unused_ok_s  = ^uio_in[7:2];
    assign uo_out       = uo_out_q;
    assign uio_out      = uio_out_q;
    assign uio_oe       = UIO_OE_MASK;

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (core_result_s),
        .z_o      (core_z_s),
        .n_o      (core_n_s),
        .c_o      (core_c_s),
        .v_o      (core_v_s)
    );

    // Next-state logic for the FSM, operand/result registers and registered outputs.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        stb_d    = stb_q;
`ifdef ALU_SEQ_MUL_EN
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        if (ena) begin
            stb_d = uio_in[0];
            if (abort_s) begin
                state_d = ST_IDLE;
                idx_d   = {IW{1'b0}};
                flags_d = FLAGS_CLR;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ev_s) begin
                            op_d    = op_e'(ui_in[2:0]);
                            flags_d = FLAGS_CLR;
                            idx_d   = {IW{1'b0}};
                            state_d = ST_LOAD_A;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_LOAD_A: begin
                        if (ev_s) begin
                            a_d[{idx_q, 3'b000} +: 8] = ui_in;
                            if (last_byte_s) begin
                                idx_d   = {IW{1'b0}};
                                state_d = ST_LOAD_B;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end else begin
                            state_d = ST_LOAD_A;
                        end
                    end
                    ST_LOAD_B: begin
                        if (ev_s) begin
                            b_d[{idx_q, 3'b000} +: 8] = ui_in;
                            if (last_byte_s) begin
                                idx_d   = {IW{1'b0}};
                                state_d = ST_EXEC;
`ifdef ALU_SEQ_MUL_EN
                                prod_d  = {(2*WIDTH){1'b0}};
                                cnt_d   = {CW{1'b0}};
`endif
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end else begin
                            state_d = ST_LOAD_B;
                        end
                    end
                    ST_EXEC: begin
`ifdef ALU_SEQ_MUL_EN
                        if (op_q == OP_MUL) begin
                            prod_d = mul_sum_s;
                            cnt_d  = cnt_q + CW'(1);
                            if (cnt_q == CW'(WIDTH - 1)) begin
                                result_d = mul_sum_s[WIDTH-1:0];
                                flags_d  = mul_flags_s;
                                idx_d    = {IW{1'b0}};
                                state_d  = ST_DONE;
                            end else begin
                                state_d = ST_EXEC;
                            end
                        end else begin
                            result_d = core_result_s;
                            flags_d  = core_flags_s;
                            idx_d    = {IW{1'b0}};
                            state_d  = ST_DONE;
                        end
`else
                        result_d = core_result_s;
                        flags_d  = core_flags_s;
                        idx_d    = {IW{1'b0}};
                        state_d  = ST_DONE;
`endif
                    end
                    ST_DONE: begin
                        if (ev_s) begin
                            if (last_byte_s) begin
                                idx_d   = {IW{1'b0}};
                                state_d = ST_IDLE;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        idx_d   = {IW{1'b0}};
                    end
                endcase
            end
        end else begin
            stb_d = stb_q;
        end
        // Outputs are computed from next-state so they line up with the state register.
        if (state_d == ST_DONE) begin
            uo_out_d = result_d[{idx_d, 3'b000} +: 8];
        end else begin
            uo_out_d = 8'h00;
        end
        uio_out_d = pack_status(flags_d, (state_d == ST_DONE), (state_d == ST_EXEC));
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            idx_q     <= {IW{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            result_q  <= {WIDTH{1'b0}};
            flags_q   <= FLAGS_CLR;
            stb_q     <= 1'b0;
            uo_out_q  <= 8'h00;
            uio_out_q <= 8'h00;
`ifdef ALU_SEQ_MUL_EN
            prod_q    <= {(2*WIDTH){1'b0}};
            cnt_q     <= {CW{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            stb_q     <= stb_d;
            uo_out_q  <= uo_out_d;
            uio_out_q <= uio_out_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/tt_um_alu_seq.md
# tt_um_alu_seq

Byte-serial, parametrised sequential ALU for the Tiny Tapeout harness; successor to the fixed-add 4-bit ALU wrapper. Takes an opcode and two WIDTH-bit operands over the 8-bit `ui_in` port with a strobe handshake, executes one of eight operations, and returns the result byte by byte on `uo_out`, with status and flags on `uio_out`. It is the top-level user module of the tile.

## Interface
- `WIDTH`, 16: operand/result width in bits. Must be a multiple of 8, range 8..32. `NB = WIDTH/8`.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: high while the tile is selected. When low, all state holds.
- `ui_in` in 8: data byte. Carries the opcode in `[2:0]`, or an operand byte.
- `uio_in` in 8: `[0]` strobe, `[1]` abort. `[7:2]` are ignored.
- `uo_out` out 8: selected result byte in DONE state, otherwise 0.
- `uio_out` out 8: `[1:0]`=0, `[2]` busy, `[3]` valid, `[4]` Z, `[5]` N, `[6]` C, `[7]` V.
- `uio_oe` out 8: constant 8'hFC.

## Operation
- **Strobe edge detect:** `stb_q` registers `uio_in[0]`. An event is `uio_in[0] & ~stb_q`. Only rising edges act.
- **FSM states:** IDLE, LOAD_A, LOAD_B, EXEC, DONE. A byte counter `idx` covers 0..NB-1.
- **IDLE:**
  - On an event, latch `ui_in[2:0]` as the opcode.
  - Clear the flags and valid, set `idx`=0, go to LOAD_A.
- **LOAD_A / LOAD_B:**
  - On each event, write `ui_in` into byte `idx` of A or B. Bytes arrive LSB first.
  - After byte NB-1 of A, go to LOAD_B with `idx`=0.
  - After byte NB-1 of B, go to EXEC.
- **EXEC:**
  - busy=1.
  - Strobes are ignored here and are not queued.
  - Single-cycle ops finish after one cycle. The result register and flags load, then the FSM goes to DONE with `idx`=0.
- **DONE:**
  - valid=1 and `uo_out`=`result[8*idx +: 8]`.
  - Each event increments `idx`.
  - The event on byte NB-1 returns the FSM to IDLE with valid=0. Flags hold until the next opcode is latched.
- **Opcodes:**
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: 1 if A<B signed, else 0.
  - 6 SHL: A << B[$clog2(WIDTH)-1:0].
  - 7 MUL (see Configuration).
- **Flags:**
  - Z: result is 0.
  - N: result[WIDTH-1].
  - C:
    - ADD: carry-out.
    - SUB: 1 when A≥B unsigned (no borrow).
    - MUL: see Configuration.
    - All other ops: 0.
  - V: signed overflow for ADD/SUB, else 0.
- **Abort:** `uio_in[1]`=1 with `ena`=1 sends the FSM to IDLE next edge from any state. It clears valid, busy, `idx` and the flags. Abort beats a simultaneous strobe.
- **ena low:** FSM, `idx`, operands and `stb_q` hold. Strobe and abort are ignored.

## Timing
- Reset values:
  - `uo_out`=0.
  - `uio_out`=0.
  - State IDLE.
  - A, B, result, opcode, `idx`, `stb_q` all 0.
- `uio_oe` is 8'hFC at all times, including during reset.
- A byte is captured on the first clk edge where the synchronous event term is true. The strobe must be low for at least 1 cycle between events.
- **Latency:** last B event edge → EXEC (busy=1 for 1 cycle) → DONE. valid rises 2 edges after the last B event is detected.
- **MUL latency:** busy for exactly WIDTH cycles, then DONE.
- Reset asserted mid-operation returns to the reset values immediately, regardless of clk.

## Configuration
- Macro: `ALU_SEQ_MUL_EN`.
- **Defined:**
  - Opcode 7 is an unsigned shift-add multiplier, one partial product per cycle, WIDTH cycles.
  - result = low WIDTH bits of the product.
  - C=1 if the high half is nonzero. V=0.
- **Undefined:**
  - No multiplier hardware.
  - Opcode 7 takes 1 cycle, result = A, C=V=0.

## Structure
- **Package `alu_seq_pkg`:**
  - Opcode enum (`OP_ADD`..`OP_MUL`).
  - FSM state enum.
  - Flag bit-index constants for `uio_out` (`BUSY_B`=2 … `V_B`=7).
  - `UIO_OE_MASK`=8'hFC.
- **Sub-module `alu_seq_core`:** combinational datapath. Parameter WIDTH; inputs A, B, opcode; outputs result, Z/N/C/V. It covers ops 0–6 and the pass-through opcode 7.
- **Top level:** FSM, edge detect, operand and result registers, and the optional multiplier.

## Test plan
All scenarios use WIDTH=16.
- ADD: events op=0, A=0x00FF (FF,00), B=0x0001 (01,00) → readout 0x00 then 0x01. Z=0, N=0, C=0, V=0. busy high exactly 1 cycle.
- SUB: A=0x0005, B=0x0005 → result 0x0000, Z=1, C=1, V=0. A=0x0003, B=0x0005 → 0xFFFE, N=1, C=0.
- Overflow: ADD 0x7FFF+0x0001 → 0x8000, N=1, V=1, C=0. ADD 0xFFFF+0x0001 → 0x0000, Z=1, C=1.
- Abort and simultaneity: abort after one B byte → IDLE, valid=0, `uo_out`=0; a fresh ADD then completes correctly. Abort and strobe on the same cycle → abort wins and no byte is captured.
- ena and EXEC guards: strobe pulses while `ena`=0 or during EXEC → no state change. Strobe held high for 5 cycles → exactly one byte captured.
- MUL 0x0100*0x0100:
  - With `ALU_SEQ_MUL_EN`: result 0x0000, C=1, busy for 16 cycles.
  - Without it: result 0x0100, busy for 1 cycle.
